// File: rtl/pipes.sv
// Shared execute-stage types: M-extension op encodings and the decode control bits
// that steer operations to the multiply/divide unit.
package pipes;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_t;

    // aluext doubles as the 32-bit word flag when mdu_en is set
    typedef struct packed {
        logic    aluext;
        logic    mdu_en;
        mdu_op_t mdu_op;
    } decode_ctrl_t;

    function automatic logic mdu_is_div(input mdu_op_t op);
        return op[2];
    endfunction

    function automatic logic mdu_is_mulh(input mdu_op_t op);
        return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_MULHU);
    endfunction

    function automatic logic mdu_is_rem(input mdu_op_t op);
        return (op == MDU_REM) || (op == MDU_REMU);
    endfunction

endpackage

// File: rtl/execute_mdu_if.sv
// Issue/result handshake between the execute stage and the iterative multiply/divide unit.
interface execute_mdu_if #(
    parameter int WIDTH = 64
) ();

    logic             in_valid;
    logic             in_ready;
    pipes::mdu_op_t   op;
    logic             word;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             busy;

    modport master (
        output in_valid, op, word, src1, src2, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, word, src1, src2, flush, out_ready,
        output in_ready, out_valid, result, busy
    );

endinterface

// File: rtl/mdu_divstep.sv
// One restoring-division step: shift the next dividend bit into the partial remainder
// and subtract the divisor when it fits.
module mdu_divstep #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    // rem_in < divisor keeps trial below 2*divisor, so a clear borrow means diff fits WIDTH bits
    always_comb begin
        trial   = {rem_in, bit_in};
        diff    = trial - {1'b0, divisor};
        q_bit   = ~diff[WIDTH];
        rem_out = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/execute_mdu.sv
// Iterative RV64M multiply/divide unit: shift-add multiply and restoring divide on operand
// magnitudes, UNROLL result bits per cycle, sign fix-up and word sign-extension at the end.
module execute_mdu import pipes::*; #(
    parameter int WIDTH  = 64,
    parameter int UNROLL = 1
) (
    input logic          clk,
    input logic          resetn,
    execute_mdu_if.slave mdu
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH / UNROLL - 1);
    localparam logic [CW-1:0] CNT_WORD = CW'(32 / UNROLL - 1);
    localparam logic [WIDTH-1:0] MIN_FULL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MIN_WORD = {{(WIDTH-31){1'b1}}, 31'd0};

    function automatic logic [WIDTH-1:0] ext32(input logic [31:0] v, input logic sgn);
        logic [WIDTH-1:0] r;
        r       = {WIDTH{sgn & v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] fix_word(input logic [WIDTH-1:0] v, input logic w);
        return w ? ext32(v[31:0], 1'b1) : v;
    endfunction

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    mdu_op_t            op_q;
    logic               word_q;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   opa_q;
    logic [WIDTH-1:0]   shf_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   result_q;

    logic             is_div;
    logic             is_rem;
    logic             word_eff;
    logic             a_signed;
    logic             b_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_ext;
    logic [WIDTH-1:0] b_ext;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] first_mag;
    logic             div_zero;
    logic             div_ovf;
    logic [WIDTH-1:0] special_res;

    // Operand conditioning: word forms narrow to 32 bits, MULH* always run full width.
    // For division the multiplier slot holds the dividend and the multiplicand slot the divisor.
    always_comb begin
        is_div    = mdu_is_div(mdu.op);
        is_rem    = mdu_is_rem(mdu.op);
        word_eff  = mdu.word & ~mdu_is_mulh(mdu.op);
        a_signed  = mdu.op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
        b_signed  = mdu.op inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
        a_ext     = word_eff ? ext32(mdu.src1[31:0], a_signed) : mdu.src1;
        b_ext     = word_eff ? ext32(mdu.src2[31:0], b_signed) : mdu.src2;
        a_neg     = a_signed & a_ext[WIDTH-1];
        b_neg     = b_signed & b_ext[WIDTH-1];
        a_mag     = a_neg ? -a_ext : a_ext;
        b_mag     = b_neg ? -b_ext : b_ext;
        first_mag = is_div ? a_mag : b_mag;
        div_zero  = is_div & (b_ext == '0);
        div_ovf   = is_div & ~mdu.op[0] & (b_ext == '1)
                  & (a_ext == (word_eff ? MIN_WORD : MIN_FULL));
        if (div_zero) special_res = is_rem ? a_ext : '1;
        else          special_res = is_rem ? '0 : a_ext;
        special_res = fix_word(special_res, word_eff);
    end

    // UNROLL chained iterations; each stage is either a shift-add or a restoring step
    for (genvar i = 0; i < UNROLL; i++) begin : g_step
        logic [2*WIDTH-1:0] acc_i;
        logic [2*WIDTH-1:0] acc_o;
        logic [WIDTH-1:0]   shf_i;
        logic [WIDTH-1:0]   shf_o;
        logic [WIDTH-1:0]   rem_nx;
        logic               q_bit;

        if (i == 0) begin : g_first
            assign acc_i = acc_q;
            assign shf_i = shf_q;
        end else begin : g_next
            assign acc_i = g_step[i-1].acc_o;
            assign shf_i = g_step[i-1].shf_o;
        end

        mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
            .rem_in  (acc_i[WIDTH-1:0]),
            .bit_in  (shf_i[WIDTH-1]),
            .divisor (opa_q),
            .rem_out (rem_nx),
            .q_bit   (q_bit)
        );

        always_comb begin
            if (op_q[2]) begin
                acc_o = {{WIDTH{1'b0}}, rem_nx};
                shf_o = {shf_i[WIDTH-2:0], q_bit};
            end else begin
                acc_o = {acc_i[2*WIDTH-2:0], 1'b0}
                      + (shf_i[WIDTH-1] ? {{WIDTH{1'b0}}, opa_q} : {(2*WIDTH){1'b0}});
                shf_o = {shf_i[WIDTH-2:0], 1'b0};
            end
        end
    end

    logic [2*WIDTH-1:0] acc_f;
    logic [WIDTH-1:0]   shf_f;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   final_res;

    // Sign fix-up of the value produced by the last iteration of the final CALC cycle
    always_comb begin
        acc_f = g_step[UNROLL-1].acc_o;
        shf_f = g_step[UNROLL-1].shf_o;
        prod  = neg_q ? -acc_f : acc_f;
        quo   = neg_q ? -shf_f : shf_f;
        rem   = neg_r ? -acc_f[WIDTH-1:0] : acc_f[WIDTH-1:0];
        case (op_q)
            MDU_MUL:                        final_res = prod[WIDTH-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: final_res = prod[2*WIDTH-1:WIDTH];
            MDU_DIV, MDU_DIVU:              final_res = quo;
            default:                        final_res = rem;
        endcase
        final_res = fix_word(final_res, word_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op_q     <= MDU_MUL;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            opa_q    <= '0;
            shf_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else if (mdu.flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mdu.in_valid) begin
                        op_q   <= mdu.op;
                        word_q <= word_eff;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        if (div_zero || div_ovf) begin
                            result_q <= special_res;
                            state    <= S_DONE;
                        end else begin
                            opa_q <= is_div ? b_mag : a_mag;
                            shf_q <= word_eff ? (first_mag << (WIDTH - 32)) : first_mag;
                            acc_q <= '0;
                            cnt   <= word_eff ? CNT_WORD : CNT_FULL;
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= acc_f;
                    shf_q <= shf_f;
                    cnt   <= cnt - CW'(1);
                    if (cnt == '0) begin
                        result_q <= final_res;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (mdu.out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mdu.in_ready  = (state == S_IDLE);
    assign mdu.out_valid = (state == S_DONE);
    assign mdu.busy      = (state != S_IDLE);
    assign mdu.result    = result_q;

endmodule

// File: tb/tb_execute_mdu.sv
// Directed bench for execute_mdu (WIDTH=64, UNROLL=1): results, latencies, stall,
// flush and asynchronous reset behaviour against hand-computed values.
module tb_execute_mdu;
    import pipes::*;

    logic clk;
    logic resetn;
    int   testsRun;
    int   testsFailed;

    execute_mdu_if #(.WIDTH(64)) mdu ();

    execute_mdu #(.WIDTH(64), .UNROLL(1)) dut (
        .clk    (clk),
        .resetn (resetn),
        .mdu    (mdu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input mdu_op_t op, input logic word,
                                 input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        mdu.op       = op;
        mdu.word     = word;
        mdu.src1     = a;
        mdu.src2     = b;
        mdu.in_valid = 1'b1;
        @(posedge clk);
        #1;
        mdu.in_valid = 1'b0;
    endtask

    // Counts cycles from the accept edge until out_valid is seen, bounded
    task automatic waitResult(input string tag, input int expLat, input logic [63:0] expRes);
        int  cyc;
        logic seen;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) checkOutput({tag, " busy"}, 64'(mdu.busy), 64'd1);
            if (mdu.out_valid) seen = 1'b1;
        end
        checkOutput({tag, " latency"}, 64'(cyc), 64'(expLat));
        checkOutput({tag, " result"}, mdu.result, expRes);
    endtask

    task automatic releaseResult();
        mdu.out_ready = 1'b1;
        @(posedge clk);
        #1;
        mdu.out_ready = 1'b0;
    endtask

    task automatic runOp(input string tag, input mdu_op_t op, input logic word,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] expRes, input int expLat);
        applyStimulus(op, word, a, b);
        waitResult(tag, expLat, expRes);
        releaseResult();
    endtask

    initial begin
        logic seenValid;
        testsRun      = 0;
        testsFailed   = 0;
        resetn        = 1'b0;
        mdu.in_valid  = 1'b0;
        mdu.op        = MDU_MUL;
        mdu.word      = 1'b0;
        mdu.src1      = '0;
        mdu.src2      = '0;
        mdu.flush     = 1'b0;
        mdu.out_ready = 1'b0;

        #12;
        checkOutput("reset in_ready", 64'(mdu.in_ready), 64'd1);
        checkOutput("reset out_valid", 64'(mdu.out_valid), 64'd0);
        checkOutput("reset busy", 64'(mdu.busy), 64'd0);
        checkOutput("reset result", mdu.result, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        runOp("MUL 3*-5", MDU_MUL, 1'b0, 64'd3, -64'sd5, 64'hFFFF_FFFF_FFFF_FFF1, 65);
        runOp("MULHU max*max", MDU_MULHU, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        runOp("MULHSU -1*2", MDU_MULHSU, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        runOp("MULH word ignored", MDU_MULH, 1'b1, 64'h8000_0000_0000_0000, 64'd2,
              64'hFFFF_FFFF_FFFF_FFFF, 65);
        runOp("DIVU 7/0", MDU_DIVU, 1'b0, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        runOp("REM 7/0", MDU_REM, 1'b0, 64'd7, 64'd0, 64'd7, 1);
        runOp("DIV min/-1", MDU_DIV, 1'b0, 64'h8000_0000_0000_0000, '1,
              64'h8000_0000_0000_0000, 1);
        runOp("REM min/-1", MDU_REM, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
        runOp("DIV -100/7", MDU_DIV, 1'b0, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65);
        runOp("REM -100/7", MDU_REM, 1'b0, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        runOp("DIVW -7/2", MDU_DIV, 1'b1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
        runOp("REMW -7/2", MDU_REM, 1'b1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        runOp("MULW 7fffffff*2", MDU_MUL, 1'b1, 64'h7FFF_FFFF, 64'd2,
              64'hFFFF_FFFF_FFFF_FFFE, 33);

        // Result held while downstream stalls for five cycles
        applyStimulus(MDU_DIVU, 1'b0, 64'd100, 64'd7);
        waitResult("stall DIVU", 65, 64'd14);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("stall out_valid", 64'(mdu.out_valid), 64'd1);
            checkOutput("stall result", mdu.result, 64'd14);
        end
        @(negedge clk);
        releaseResult();
        @(negedge clk);
        checkOutput("post-stall in_ready", 64'(mdu.in_ready), 64'd1);
        checkOutput("post-stall out_valid", 64'(mdu.out_valid), 64'd0);

        // Flush in CALC cycle 10 while a new op is offered
        applyStimulus(MDU_MUL, 1'b0, 64'd3, 64'd5);
        repeat (10) @(negedge clk);
        mdu.flush    = 1'b1;
        mdu.in_valid = 1'b1;
        mdu.op       = MDU_DIVU;
        mdu.src1     = 64'd5;
        mdu.src2     = 64'd0;
        @(posedge clk);
        #1;
        mdu.flush    = 1'b0;
        mdu.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("flush in_ready", 64'(mdu.in_ready), 64'd1);
        checkOutput("flush busy", 64'(mdu.busy), 64'd0);
        checkOutput("flush stale result", mdu.result, 64'd14);
        seenValid = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (mdu.out_valid) seenValid = 1'b1;
        end
        checkOutput("flush no out_valid", 64'(seenValid), 64'd0);
        runOp("DIVU 100/7 after flush", MDU_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65);

        // Asynchronous reset mid-CALC
        applyStimulus(MDU_REMU, 1'b0, 64'd100, 64'd7);
        repeat (20) @(negedge clk);
        resetn = 1'b0;
        #1;
        checkOutput("async reset in_ready", 64'(mdu.in_ready), 64'd1);
        checkOutput("async reset out_valid", 64'(mdu.out_valid), 64'd0);
        checkOutput("async reset busy", 64'(mdu.busy), 64'd0);
        checkOutput("async reset result", mdu.result, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        runOp("REMU 100/7 after reset", MDU_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 65);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/execute_mdu.md
# execute_mdu

Iterative RV64M multiply/divide unit sitting beside the single-cycle ALU in the execute stage, generalising it to multi-cycle operation. It accepts one operation at a time through a valid/ready handshake and computes it over a parametrised number of iterations, covering all M-extension ops including the 32-bit word forms. It presents the sign-corrected, optionally sign-extended result and holds it until the pipeline accepts it. A flush discards work in flight, for branch mispredicts and traps.

## Interface
- `WIDTH`, 64: datapath width; 32 or 64.
- `UNROLL`, 1: result bits resolved per CALC cycle; 1, 2 or 4; must divide 32.
- `clk` in 1: clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operation offered.
- `in_ready` out 1: unit can accept; high only in IDLE.
- `op` in `mdu_op_t` (3): MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- `word` in 1: 32-bit form; honoured for MUL/DIV/DIVU/REM/REMU, ignored for MULH*.
- `src1`, `src2` in WIDTH: operands, already forwarded.
- `flush` in 1: abort and discard.
- `out_valid` out 1: `result` valid.
- `out_ready` in 1: downstream accepts result.
- `result` out WIDTH: final value.
- `busy` out 1: state is not IDLE; feeds the hazard unit stall.

## Operation
- FSM has three states.
  - IDLE: `in_ready`=1. On `in_valid & !flush`, latch op, word, and operand magnitudes plus sign flags.
  - Normal case goes to CALC and loads counter = N−1.
  - Special case goes to DONE.
- Word mode:
  - Operands are `src[31:0]`, sign-extended for signed ops and zero-extended for unsigned ops.
  - Result is `res[31:0]` sign-extended to WIDTH.
  - N = 32/UNROLL.
- Full-width mode: N = WIDTH/UNROLL.
- Multiply is shift-add on magnitudes, producing a 2·WIDTH product.
  - MUL returns the low half.
  - MULH* return the high half.
  - Product is negated when the signs of the signed-interpreted operands differ.
  - MULHSU treats src2 as unsigned.
- Divide is restoring, UNROLL steps per cycle.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
- Special cases resolve in one cycle with no CALC:
  - Divisor 0: quotient all-ones (DIV/DIVU), remainder = dividend (REM/REMU).
  - Signed overflow (min / −1): quotient = min, remainder 0. Word mode uses the 32-bit min.
- CALC decrements the counter each cycle. At counter 0 it registers the sign-fixed and extended `result`, then goes to DONE.
- DONE: `out_valid`=1 and `result` is held stable. On `out_ready`, go to IDLE.
- `flush` has priority in every state:
  - Next state is IDLE and `out_valid` drops next cycle.
  - `in_valid` in the same cycle is not accepted.
  - `result` keeps its stale value.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `result`=0, counter 0, operand registers 0.
- Reset asserted mid-operation aborts immediately, with no output.
- Accept at cycle 0 edge. CALC occupies cycles 1..N and `out_valid` rises in cycle N+1.
  - WIDTH=64, UNROLL=1: 65-cycle latency; word ops 33.
  - Special cases: `out_valid` in cycle 1.
- Throughput: the next accept is possible one cycle after the DONE handshake, because the DONE→IDLE edge happens first.
- `in_ready` is registered from state, with no combinational path from `in_valid`. `out_valid`, `busy` and `result` are also registered.

## Structure
- `mdu_op_t` enum lives in the shared `pipes` package.
- `MDU_` constants (op encodings) also live in `pipes`.
- The decode control struct gains `mdu_en`, `mdu_op` and `aluext` reuse for `word`.
- One sub-module, `mdu_divstep`: combinational single restoring-division step (partial remainder, divisor → next remainder, quotient bit). It is instantiated UNROLL times in a chain.
- The multiply add/shift stays inline.

## Test plan
- MUL 3 × −5, WIDTH=64, UNROLL=1 → `result`=0xFFFF_FFFF_FFFF_FFF1, `out_valid` rises exactly cycle 65 after accept; MULHU 0xFFFF_FFFF_FFFF_FFFF² → 0xFFFF_FFFF_FFFF_FFFE.
- DIVU 7/0 → 0xFFFF_FFFF_FFFF_FFFF in cycle 1; REM 7/0 → 7; DIV 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000; REM same → 0.
- DIVW −7/2 → 0xFFFF_FFFF_FFFF_FFFD, REMW → 0xFFFF_FFFF_FFFF_FFFF, each after 33 cycles; MULW 0x7FFF_FFFF × 2 → 0xFFFF_FFFF_FFFF_FFFE.
- `out_ready` held low 5 cycles in DONE → `result`/`out_valid` stable throughout; accept on cycle 6, `in_ready` high next cycle.
- `flush` in CALC cycle 10 with `in_valid` high → no accept, IDLE next cycle, no `out_valid`; a new DIVU 100/7 then returns 14.
- `resetn` pulsed low mid-CALC → all outputs at reset values asynchronously; after release, REMU 100/7 → 2.
